// File: rtl/prefetch_queue.sv
`timescale 1ns/1ps
// Instruction prefetch: fetches code words from cs:ip into a byte FIFO that feeds the decoder.
// Latency: request issued the cycle after IDLE sees room; bytes readable the cycle after mem_ack.
// Backpressure: fetching pauses while fewer than two byte slots are free; a bus cycle is never abandoned.
module prefetch_queue #(
  parameter int QUEUE_DEPTH = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cs,
  input  logic [15:0] new_ip,
  input  logic        load_new_ip,
  output logic        mem_access,
  output logic [18:0] mem_address,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  input  logic        fifo_rd_en,
  output logic [7:0]  fifo_rd_data,
  output logic        fifo_empty
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_e;

  state_e          state_q, state_d;
  logic [15:0]     fetch_ip_q, fetch_ip_d;
  logic [18:0]     mem_address_q, mem_address_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [7:0]      fifo_mem_q [QUEUE_DEPTH];
  logic [7:0]      fifo_mem_d [QUEUE_DEPTH];
  logic            push_two;
  logic            push_one;
  logic            pop;

  // Pointers advance modulo the queue depth, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(QUEUE_DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign mem_access   = (state_q != IDLE);
  assign mem_address  = mem_address_q;
  assign fifo_empty   = (count_q == CW'(0));
  assign fifo_rd_data = fifo_mem_q[rd_ptr_q];

  // Next-state, bus address and push decisions; a branch overrides the fetch offset.
  always_comb begin
    state_d       = state_q;
    fetch_ip_d    = fetch_ip_q;
    mem_address_d = mem_address_q;
    push_two      = 1'b0;
    push_one      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!load_new_ip && (count_q <= CW'(QUEUE_DEPTH - 2))) begin
          state_d = FETCH;
          // (cs*16 + ip) / 2 == cs*8 + ip/2, since cs*16 is even.
          mem_address_d = {cs, 3'b000} + {4'b0000, fetch_ip_q[15:1]};
        end
      end
      FETCH: begin
        if (mem_ack) begin
          state_d = IDLE;
          if (!load_new_ip) begin
            if (fetch_ip_q[0]) begin
              push_one   = 1'b1;
              fetch_ip_d = fetch_ip_q + 16'd1;
            end else begin
              push_two   = 1'b1;
              fetch_ip_d = fetch_ip_q + 16'd2;
            end
          end
        end else if (load_new_ip) begin
          // The outstanding bus cycle must complete; its data will be dropped.
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_new_ip) begin
      fetch_ip_d = new_ip;
    end
  end

  // Byte FIFO: up to two pushes and one pop per cycle; a branch empties it.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pop        = fifo_rd_en && (count_q != CW'(0));
    if (push_two) begin
      fifo_mem_d[wr_ptr_q]          = mem_data[7:0];
      fifo_mem_d[ptr_inc(wr_ptr_q)] = mem_data[15:8];
      wr_ptr_d                      = ptr_inc(ptr_inc(wr_ptr_q));
    end else if (push_one) begin
      fifo_mem_d[wr_ptr_q] = mem_data[15:8];
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q
            + (push_two ? CW'(2) : (push_one ? CW'(1) : CW'(0)))
            - (pop ? CW'(1) : CW'(0));
    if (load_new_ip) begin
      count_d  = CW'(0);
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  // State registers; reset drops any bus request immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      fetch_ip_q    <= '0;
      mem_address_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      fetch_ip_q    <= fetch_ip_d;
      mem_address_q <= mem_address_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fifo_mem_q    <= fifo_mem_d;
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
`timescale 1ns/1ps
// Directed bench for prefetch_queue: scoreboard of expected bytes fed on each ack, drained on pops.
// Timing: inputs change and outputs are sampled 1ns after each rising edge.
// Every bus wait is bounded; an expired bound counts as a failed comparison.
module tb_prefetch_queue;

  logic        clk;
  logic        reset;
  logic [15:0] cs;
  logic [15:0] new_ip;
  logic        load_new_ip;
  logic        mem_access;
  logic [18:0] mem_address;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  sb[$];
  logic [15:0] m_ip;

  prefetch_queue #(.QUEUE_DEPTH(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .cs          (cs),
    .new_ip      (new_ip),
    .load_new_ip (load_new_ip),
    .mem_access  (mem_access),
    .mem_address (mem_address),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (mem_access !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(mem_access), 32'd1);
  endtask

  // Serve one bus request after 'delay' extra cycles and record the bytes it should queue.
  task automatic fetch(input string tag, input logic [18:0] exp_addr,
                       input logic [15:0] d, input int delay);
    wait_req(tag);
    chk({tag, "_addr"}, 32'(mem_address), 32'(exp_addr));
    for (int i = 0; i < delay; i++) begin
      tick();
      chk({tag, "_hold"}, 32'({mem_access, mem_address}), 32'({1'b1, exp_addr}));
    end
    mem_ack  = 1'b1;
    mem_data = d;
    tick();
    mem_ack  = 1'b0;
    mem_data = 16'h0000;
    chk({tag, "_drop"}, 32'(mem_access), 32'd0);
    if (m_ip[0]) begin
      sb.push_back(d[15:8]);
      m_ip = m_ip + 16'd1;
    end else begin
      sb.push_back(d[7:0]);
      sb.push_back(d[15:8]);
      m_ip = m_ip + 16'd2;
    end
  endtask

  task automatic pop_byte(input string tag);
    logic [7:0] e;
    e = 8'hxx;
    if (sb.size() > 0) e = sb.pop_front();
    chk({tag, "_ne"}, 32'(fifo_empty), 32'd0);
    chk(tag, 32'(fifo_rd_data), 32'(e));
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    cs          = 16'h1000;
    new_ip      = 16'h0000;
    load_new_ip = 1'b1;
    mem_ack     = 1'b0;
    mem_data    = 16'h0000;
    fifo_rd_en  = 1'b0;
    m_ip        = 16'h0000;
    #12;
    chk("rst_access", 32'(mem_access), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_data", 32'(fifo_rd_data), 32'd0);

    // Test 1: cs=0x1000, ip=0, fill queue to six bytes.
    tick();
    reset = 1'b1;
    tick();
    load_new_ip = 1'b0;
    chk("t1_gap", 32'(mem_access), 32'd0);
    fetch("t1_a", 19'h08000, 16'h3412, 1);
    fetch("t1_b", 19'h08001, 16'h7856, 1);
    fetch("t1_c", 19'h08002, 16'hBC9A, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_full_idle", 32'(mem_access), 32'd0);
    end

    // Tests 4/5: pop down to four, then push and pop in the same cycle.
    pop_byte("t4_p0");
    pop_byte("t4_p1");
    wait_req("t5");
    chk("t5_addr", 32'(mem_address), 32'h08003);
    chk("t5_head", 32'(fifo_rd_data), 32'(sb[0]));
    void'(sb.pop_front());
    mem_ack    = 1'b1;
    mem_data   = 16'hF0DE;
    fifo_rd_en = 1'b1;
    tick();
    mem_ack    = 1'b0;
    mem_data   = 16'h0000;
    fifo_rd_en = 1'b0;
    sb.push_back(8'hDE);
    sb.push_back(8'hF0);
    m_ip = m_ip + 16'd2;
    chk("t5_drop", 32'(mem_access), 32'd0);
    chk("t5_adv", 32'(fifo_rd_data), 32'h78);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_cnt5_idle", 32'(mem_access), 32'd0);
    end
    for (int i = 0; i < 5; i++) pop_byte("t4_drain");
    chk("t4_empty", 32'(fifo_empty), 32'd1);
    fetch("t4_f", 19'h08004, 16'h3C2B, 0);

    // Test 3: branch during FETCH, ack three cycles later.
    wait_req("t3");
    chk("t3_addr", 32'(mem_address), 32'h08005);
    new_ip      = 16'h0100;
    load_new_ip = 1'b1;
    tick();
    load_new_ip = 1'b0;
    sb.delete();
    m_ip = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      chk("t3_discard", 32'({mem_access, mem_address, fifo_empty}), 32'({1'b1, 19'h08005, 1'b1}));
      if (i < 2) tick();
    end
    mem_ack  = 1'b1;
    mem_data = 16'hFFFF;
    tick();
    mem_ack  = 1'b0;
    mem_data = 16'h0000;
    chk("t3_after", 32'({mem_access, fifo_empty}), 32'b01);
    fetch("t3_new", 19'h08080, 16'h2211, 0);
    pop_byte("t3_p0");
    pop_byte("t3_p1");

    // Test 2: branch coincident with ack, then segment-top wrap.
    wait_req("t2_pend");
    chk("t2_pend_addr", 32'(mem_address), 32'h08081);
    cs          = 16'hF000;
    new_ip      = 16'hFFFF;
    load_new_ip = 1'b1;
    mem_ack     = 1'b1;
    mem_data    = 16'h9999;
    tick();
    load_new_ip = 1'b0;
    mem_ack     = 1'b0;
    mem_data    = 16'h0000;
    sb.delete();
    m_ip = 16'hFFFF;
    chk("t2_flush", 32'({mem_access, fifo_empty}), 32'b01);
    fetch("t2_wrap", 19'h7FFFF, 16'hAB12, 0);
    chk("t2_ip", 32'(m_ip), 32'h0000);
    fetch("t2_zero", 19'h78000, 16'h5544, 0);
    pop_byte("t2_p0");
    pop_byte("t2_p1");
    pop_byte("t2_p2");

    // Test 6: reset while a request is outstanding.
    wait_req("t6_pend");
    reset = 1'b0;
    #1;
    chk("t6_rst", 32'({mem_access, fifo_empty, mem_address}), 32'({1'b0, 1'b1, 19'h0}));
    cs = 16'h2000;
    tick();
    reset = 1'b1;
    sb.delete();
    m_ip = 16'h0000;
    fetch("t6", 19'h10000, 16'h0201, 0);
    pop_byte("t6_p0");
    pop_byte("t6_p1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
